// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0] ADJ_OFFSET    = 4'd3;

  // Used to prove at elaboration that DIGITS decimal digits can hold any WIDTH-bit value.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and data bus between a requester and the converter.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One BCD nibble of the double-dabble adjust step: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= ADJ_THRESHOLD) ? (i_nibble + ADJ_OFFSET) : i_nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// The result register only changes on the completing edge, so a display never sees partial digits.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus
);

  localparam int W  = WIDTH + 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_digits_too_few
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t              r_state;
  state_t              w_nextState;
  logic [W-1:0]        r_work;
  logic [CW-1:0]       r_count;
  logic [4*DIGITS-1:0] r_bcd;
  logic [W-1:0]        w_adjusted;
  logic [W-1:0]        w_shifted;
  logic                w_lastShift;

  assign w_adjusted[WIDTH-1:0] = r_work[WIDTH-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nibble (r_work[WIDTH + 4*i +: 4]),
      .o_nibble (w_adjusted[WIDTH + 4*i +: 4])
    );
  end

  assign w_shifted   = w_adjusted << 1;
  assign w_lastShift = (r_count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = SHIFT;
      SHIFT:   if (w_lastShift) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Work register, shift counter and the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work  <= '0;
      r_count <= '0;
      r_bcd   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_work  <= {{(4*DIGITS){1'b0}}, bus.bin};
            r_count <= '0;
          end
        end
        SHIFT: begin
          r_work  <= w_shifted;
          r_count <= r_count + CW'(1);
          if (w_lastShift) r_bcd <= w_shifted[W-1 -: 4*DIGITS];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy = (r_state == SHIFT);
    bus.done = (r_state == DONE);
    bus.bcd  = r_bcd;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [4*DIGITS-1:0] expBcd;
  logic [WIDTH-1:0]    streamQ[$];

  function automatic logic [4*DIGITS-1:0] toBcd(input int value);
    logic [4*DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One full conversion; optionally fires stray starts during SHIFT and DONE that must be ignored.
  task automatic applyStimulus(input logic [WIDTH-1:0] value, input bit pulseIgnored);
    int latency, busyCycles, overlap, unstable, c, idleBusy;
    logic [WIDTH-1:0] other;
    other = value ^ 10'h2AA;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = value;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = ~value;
    latency = -1; busyCycles = 0; overlap = 0; unstable = 0; c = 0;
    while (c < 40 && latency < 0) begin
      if (bus.busy) busyCycles++;
      if (bus.busy && bus.done) overlap++;
      if (bus.done) latency = c;
      else if (bus.bcd !== expBcd) unstable++;
      if (pulseIgnored) begin
        bus.start = (c == 3) || bus.done;
        bus.bin   = other;
      end
      if (latency < 0) begin
        @(negedge clk);
        c++;
      end
    end
    expBcd = toBcd(int'(value));
    checkOutput("latency", 32'(latency), 32'(WIDTH));
    checkOutput("busy_cycles", 32'(busyCycles), 32'(WIDTH));
    checkOutput("busy_done_overlap", 32'(overlap), 32'd0);
    checkOutput("bcd_hold", 32'(unstable), 32'd0);
    checkOutput("bcd_result", 32'(bus.bcd), 32'(expBcd));
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
    if (pulseIgnored) begin
      idleBusy = 0;
      for (int k = 0; k < 3; k++) begin
        if (bus.busy) idleBusy++;
        @(negedge clk);
      end
      checkOutput("stray_start_queued", 32'(idleBusy), 32'd0);
      checkOutput("bcd_after_stray", 32'(bus.bcd), 32'(expBcd));
    end
  endtask

  initial begin
    int sawDone;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    expBcd    = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_bcd", 32'(bus.bcd), 32'd0);
    reset = 1'b0;

    applyStimulus(10'd1023, 1'b0);
    applyStimulus(10'd0, 1'b0);
    applyStimulus(10'd999, 1'b0);
    applyStimulus(10'd500, 1'b0);
    applyStimulus(10'd777, 1'b1);

    // Start held high: the DUT accepts every 12 edges, capturing whatever bin is present then.
    @(negedge clk);
    for (int k = 0; k < 60; k++) begin
      bus.start = 1'b1;
      bus.bin   = WIDTH'($urandom);
      if (k % 12 == 0) streamQ.push_back(bus.bin);
      @(negedge clk);
      checkOutput("stream_done", 32'(bus.done), 32'((k % 12) == 10));
      if (bus.done && streamQ.size() > 0) begin
        expBcd = toBcd(int'(streamQ.pop_front()));
        checkOutput("stream_bcd", 32'(bus.bcd), 32'(expBcd));
      end
    end
    bus.start = 1'b0;
    checkOutput("stream_pending", 32'(streamQ.size()), 32'd0);

    // Abort a conversion with reset during its fifth shift cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 10'd1023;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expBcd = '0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_bcd", 32'(bus.bcd), 32'd0);
    sawDone = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.done || bus.busy) sawDone++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);

    for (int k = 0; k < 20; k++)
      applyStimulus(WIDTH'($urandom_range(0, 1023)), 1'(k % 3 == 0));

    for (int v = 0; v < 1024; v++)
      applyStimulus(WIDTH'(v), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
